fir_coeff_loader: RTL
=====================

FIR_COEFF_LOADER -- requirements
Module: fir_coeff_loader

Interface
REQ-001 SHALL have parameter COEFF_WIDTH, default 6, the bit width of one signed two's-complement coefficient.
REQ-002 SHALL have parameter NUM_TAPS, default 4, the number of coefficients per set (minimum 2).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, an asynchronous active-low reset.
REQ-005 SHALL have port coef_in, input, COEFF_WIDTH bits, one serial coefficient word.
REQ-006 SHALL have port coef_valid, input, 1 bit: coef_in is valid.
REQ-007 SHALL have port coef_last, input, 1 bit, marking the final word of a set.
REQ-008 SHALL have port coef_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-009 SHALL have port coeff, output, NUM_TAPS*COEFF_WIDTH bits, the packed coefficient bus that drives the fir coeff input.
REQ-010 SHALL have port coeff_update, output, 1 bit, a one-cycle pulse when coeff changes.
REQ-011 SHALL have port load_err, output, 1 bit, a one-cycle pulse when a set is discarded; this port exists only under FIR_COEFF_LOADER_CHECK_EN.

Function
REQ-012 SHALL accept a word only on a cycle where coef_valid=1 and coef_ready=1 (a "beat").
REQ-013 SHALL treat word 0 of a set as tap 0 and pack it at the MSBs: coeff[NUM_TAPS*COEFF_WIDTH-1 -: COEFF_WIDTH].
REQ-014 SHALL collect beats into an internal shadow register, leaving coeff unchanged until the set is complete.
REQ-015 SHALL use FSM states IDLE, LOAD, COMMIT and DRAIN.
REQ-016 SHALL make these state transitions:
- IDLE -> LOAD on the first beat.
- LOAD -> COMMIT on beat NUM_TAPS.
- COMMIT -> IDLE unconditionally after one cycle.
REQ-017 SHALL drive coef_ready=1 in IDLE, LOAD and DRAIN, and coef_ready=0 in COMMIT.
REQ-018 SHALL, when the final beat occurs in cycle k, present the new set on coeff from cycle k+1 and pulse coeff_update=1 in cycle k+1 only.
REQ-019 SHALL update all taps of coeff on a single edge; a partially updated coeff SHALL never be visible.
REQ-020 SHALL hold a beat count of ceil(log2(NUM_TAPS)) bits that resets to 0 on entry to IDLE; the count SHALL NOT wrap.
REQ-021 SHALL register coef_in without arithmetic, storing the sign bits unchanged.
REQ-022 SHALL ignore coef_valid=0 cycles mid-set; gaps of any length are allowed.

Reset
REQ-023 SHALL, while rst_n=0, force state=IDLE, count=0, shadow=0, coeff=0, coeff_update=0 and load_err=0.
REQ-024 SHALL discard a partial set on reset asserted mid-load, leaving coeff=0 after reset.
REQ-025 SHALL not produce a coeff_update pulse on reset release.

Configuration
REQ-026 SHALL use the macro FIR_COEFF_LOADER_CHECK_EN to enable framing checks, with this behaviour when defined:
- coef_last on beat n<NUM_TAPS discards the set, pulses load_err in the next cycle and returns to IDLE.
- coef_last=0 on beat NUM_TAPS discards the set and enters DRAIN.
- DRAIN drops beats until a beat with coef_last=1, then pulses load_err and returns to IDLE.
- coeff is unchanged in all of these cases.
REQ-027 SHALL, when FIR_COEFF_LOADER_CHECK_EN is undefined, ignore coef_last, commit after every NUM_TAPS beats, omit the load_err port and never enter DRAIN.

Structure
REQ-028 SHALL place the FSM state encoding and the default COEFF_WIDTH/NUM_TAPS localparams in the shared package mso_fir_pkg, reused by fir.
REQ-029 SHALL implement the word-to-tap packing in one sub-module, coeff_shift_reg: a serial-in parallel-out register with enable and clear.

Verification
REQ-030 SHALL verify a normal load: beats 4, 3, -1, -2 with last on -2 -> coeff=24'h103FFE from the cycle after the 4th beat, coeff_update high exactly one cycle.
REQ-031 SHALL verify gaps and back-pressure: the same set with coef_valid low 3 cycles between beats -> same result; valid held high -> coef_ready=0 in the COMMIT cycle and no word lost; a second set 1, 0, 0, 0 -> coeff=24'h040000.
REQ-032 SHALL verify an early last (CHECK_EN): beats 5, 6 with last on 6 -> load_err pulse, coeff keeps 24'h103FFE, no coeff_update.
REQ-033 SHALL verify a missing last (CHECK_EN): 6 beats with last on the 6th -> DRAIN, load_err after the 6th beat, coeff unchanged; a following good set commits normally.
REQ-034 SHALL verify reset mid-load: rst_n=0 after 2 beats -> coeff=0 and coef_ready=1 immediately; after release a full set 4, 3, -1, -2 -> 24'h103FFE.
REQ-035 SHALL verify with FIR_COEFF_LOADER_CHECK_EN undefined: 8 beats with no last -> two commits and two coeff_update pulses.

Source files
------------

// File: rtl/mso_fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mso_fir_pkg                                                        |
// | Shared FIR defaults and coefficient-loader state encoding.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mso_fir_pkg;

  localparam int c_default_coeff_width = 6;
  localparam int c_default_num_taps    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2,
    DRAIN  = 2'd3
  } loader_state_e;

endpackage
`default_nettype wire

// File: rtl/coeff_shift_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | coeff_shift_reg                                                    |
// | Serial-in parallel-out coefficient shadow with enable and clear.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module coeff_shift_reg
  import mso_fir_pkg::*;
#(
  parameter int COEFF_WIDTH = c_default_coeff_width,
  parameter int NUM_TAPS    = c_default_num_taps
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            en,
  input  logic [COEFF_WIDTH-1:0]          din,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] q_next
);

  localparam int c_width = NUM_TAPS * COEFF_WIDTH;

  logic [c_width-1:0] r_shadow;

  // Shifting toward the MSBs leaves the first word of a set at the top.
  assign q_next = {r_shadow[c_width-COEFF_WIDTH-1:0], din};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
    end else if (clr) begin
      r_shadow <= '0;
    end else if (en) begin
      r_shadow <= q_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_coeff_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fir_coeff_loader                                                   |
// | Serial coefficient loader; commits a full set to coeff at once.    |
// | Framing checks and load_err enabled by FIR_COEFF_LOADER_CHECK_EN.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module fir_coeff_loader
  import mso_fir_pkg::*;
#(
  parameter int COEFF_WIDTH = c_default_coeff_width,
  parameter int NUM_TAPS    = c_default_num_taps
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [COEFF_WIDTH-1:0]          coef_in,
  input  logic                            coef_valid,
  input  logic                            coef_last,
  output logic                            coef_ready,
  output logic [NUM_TAPS*COEFF_WIDTH-1:0] coeff,
  output logic                            coeff_update
`ifdef FIR_COEFF_LOADER_CHECK_EN
  ,
  output logic                            load_err
`endif
);

  localparam int c_cnt_w = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(NUM_TAPS - 1);

  loader_state_e                     r_state, w_state_next;
  logic [c_cnt_w-1:0]                r_count, w_count_next;
  logic [NUM_TAPS*COEFF_WIDTH-1:0]   r_coeff;
  logic [NUM_TAPS*COEFF_WIDTH-1:0]   w_shadow_next;
  logic                              w_beat;
  logic                              w_shift_en;
  logic                              w_shift_clr;
  logic                              w_commit;
  logic                              w_err;
  logic                              w_early_end;
  logic                              w_good_end;

`ifdef FIR_COEFF_LOADER_CHECK_EN
  logic r_load_err;
  assign w_early_end = coef_last;
  assign w_good_end  = coef_last;
`else
  // Without framing checks the set boundary is purely the beat count.
  logic w_unused_err;
  assign w_early_end  = 1'b0;
  assign w_good_end   = 1'b1;
  assign w_unused_err = w_err;
`endif

  assign coef_ready   = (r_state != COMMIT);
  assign w_beat       = coef_valid && coef_ready;
  assign coeff        = r_coeff;
  assign coeff_update = (r_state == COMMIT);

  coeff_shift_reg #(
    .COEFF_WIDTH (COEFF_WIDTH),
    .NUM_TAPS    (NUM_TAPS)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_shift_clr),
    .en     (w_shift_en),
    .din    (coef_in),
    .q_next (w_shadow_next)
  );

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_shift_en   = 1'b0;
    w_shift_clr  = 1'b0;
    w_commit     = 1'b0;
    w_err        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_beat) begin
          if (w_early_end) begin
            w_shift_clr = 1'b1;
            w_err       = 1'b1;
          end else begin
            w_shift_en   = 1'b1;
            w_count_next = c_cnt_w'(1);
            w_state_next = LOAD;
          end
        end
      end
      LOAD: begin
        if (w_beat) begin
          if (r_count == c_last_cnt) begin
            // The final word goes straight to coeff alongside the shadow.
            w_shift_clr  = 1'b1;
            w_count_next = '0;
            if (w_good_end) begin
              w_commit     = 1'b1;
              w_state_next = COMMIT;
            end else begin
              w_state_next = DRAIN;
            end
          end else if (w_early_end) begin
            w_shift_clr  = 1'b1;
            w_err        = 1'b1;
            w_count_next = '0;
            w_state_next = IDLE;
          end else begin
            w_shift_en   = 1'b1;
            w_count_next = r_count + 1'b1;
          end
        end
      end
      COMMIT: begin
        w_count_next = '0;
        w_state_next = IDLE;
      end
      DRAIN: begin
        if (w_beat && coef_last) begin
          w_err        = 1'b1;
          w_count_next = '0;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_count_next = '0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_count <= '0;
      r_coeff <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (w_commit) begin
        r_coeff <= w_shadow_next;
      end
    end
  end

`ifdef FIR_COEFF_LOADER_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_load_err <= 1'b0;
    end else begin
      r_load_err <= w_err;
    end
  end
  assign load_err = r_load_err;
`endif

endmodule
`default_nettype wire
